// File: rtl/ant_signal_sensor.sv
// ant_signal_sensor
//   Reads the up-to-8 neighbouring pheromone cells around one ant through a
//   single-outstanding read handshake and reports the strongest direction.
//
//   Ports:
//     Clk, Reset          clock, synchronous active-high reset
//     start               sense request (accepted only when idle)
//     ant_x, ant_y        ant position, latched on accepted start
//     cur_dir             ant heading, latched on accepted start (tie-break)
//     rd_req, rd_x, rd_y  grid read request and address
//     rd_valid, rd_data   read completion and cell signal value
//     busy                high whenever a sense is in progress
//     done                one-cycle pulse when the result outputs update
//     best_dir            direction of strongest neighbour (0=N .. 7=NW clockwise)
//     best_signal         signal value at best_dir
//     found               usable gradient flag
//
//   Optional feature: define ANT_SENSE_CENTER_EN to read the ant's own cell
//   first; found then also requires best_signal to exceed that center value.
module ant_signal_sensor #(
  parameter int SIGNAL_bits  = 16,
  parameter int GRID_W       = 64,
  parameter int GRID_H       = 64,
  parameter int X_bits       = 6,
  parameter int Y_bits       = 6,
  parameter int SENSE_THRESH = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [X_bits-1:0]      ant_x,
  input  logic [Y_bits-1:0]      ant_y,
  input  logic [2:0]             cur_dir,
  output logic                   rd_req,
  output logic [X_bits-1:0]      rd_x,
  output logic [Y_bits-1:0]      rd_y,
  input  logic                   rd_valid,
  input  logic [SIGNAL_bits-1:0] rd_data,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             best_dir,
  output logic [SIGNAL_bits-1:0] best_signal,
  output logic                   found
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [X_bits-1:0]      X_MAX  = X_bits'(GRID_W - 1);
  localparam logic [Y_bits-1:0]      Y_MAX  = Y_bits'(GRID_H - 1);
  localparam logic [SIGNAL_bits-1:0] THRESH = SIGNAL_bits'(SENSE_THRESH);

  logic [1:0]             state;
  logic [X_bits-1:0]      antX;
  logic [Y_bits-1:0]      antY;
  logic [2:0]             curDir;
  logic [2:0]             dirIdx;
  logic [2:0]             runDir;
  logic [SIGNAL_bits-1:0] runMax;
  logic                   anyRead;
`ifdef ANT_SENSE_CENTER_EN
  logic                   centerPhase;
  logic [SIGNAL_bits-1:0] centerSig;
`endif

  logic dxPos, dxNeg, dyPos, dyNeg;
  logic atCenter, offGrid, hit, sample, stepDone;
  logic [X_bits-1:0]      nbrX;
  logic [Y_bits-1:0]      nbrY;
  logic [SIGNAL_bits-1:0] nextMax;
  logic [2:0]             nextDir;
  logic                   nextAny, nextFound;

  // Offset of the current direction; y grows southward.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dxPos = 1'b0;
    dxNeg = 1'b0;
    dyPos = 1'b0;
    dyNeg = 1'b0;
    case (dirIdx)
      3'd0: dyNeg = 1'b1;
      3'd1: begin dxPos = 1'b1; dyNeg = 1'b1; end
      3'd2: dxPos = 1'b1;
      3'd3: begin dxPos = 1'b1; dyPos = 1'b1; end
      3'd4: dyPos = 1'b1;
      3'd5: begin dxNeg = 1'b1; dyPos = 1'b1; end
      3'd6: dxNeg = 1'b1;
      3'd7: begin dxNeg = 1'b1; dyNeg = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    atCenter = 1'b0;
`ifdef ANT_SENSE_CENTER_EN
    atCenter = centerPhase;
`endif
    // Off-grid only when a step would cross an edge the ant sits on, so the
    // address arithmetic below never needs to wrap.
    offGrid = !atCenter &&
              ((dxNeg && antX == '0) || (dxPos && antX == X_MAX) ||
               (dyNeg && antY == '0) || (dyPos && antY == Y_MAX));
    nbrX = antX;
    nbrY = antY;
    if (!atCenter) begin
      if (dxPos) nbrX = antX + X_bits'(1);
      if (dxNeg) nbrX = antX - X_bits'(1);
      if (dyPos) nbrY = antY + Y_bits'(1);
      if (dyNeg) nbrY = antY - Y_bits'(1);
    end
  end

  assign rd_req   = (state == SCAN) && !offGrid;
  assign rd_x     = rd_req ? nbrX : '0;
  assign rd_y     = rd_req ? nbrY : '0;
  assign hit      = rd_req && rd_valid;
  assign sample   = hit && !atCenter;
  assign stepDone = (state == SCAN) && (offGrid || hit);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Running max including the read completing this cycle, so the final
  // neighbour can be folded straight into the result registers.
  always_comb begin
    nextMax = runMax;
    nextDir = runDir;
    nextAny = anyRead;
    if (sample) begin
      nextAny = 1'b1;
      if (rd_data > runMax) begin
        nextMax = rd_data;
        nextDir = dirIdx;
      end else if (rd_data == runMax && dirIdx == curDir) begin
        nextDir = curDir;
      end
    end
  end

`ifdef ANT_SENSE_CENTER_EN
  assign nextFound = nextAny && (nextMax >= THRESH) && (nextMax > centerSig);
`else
  assign nextFound = nextAny && (nextMax >= THRESH);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      antX        <= '0;
      antY        <= '0;
      curDir      <= '0;
      dirIdx      <= '0;
      runDir      <= '0;
      runMax      <= '0;
      anyRead     <= 1'b0;
      best_dir    <= '0;
      best_signal <= '0;
      found       <= 1'b0;
`ifdef ANT_SENSE_CENTER_EN
      centerPhase <= 1'b0;
      centerSig   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            antX    <= ant_x;
            antY    <= ant_y;
            curDir  <= cur_dir;
            runMax  <= '0;
            runDir  <= cur_dir;
            anyRead <= 1'b0;
            dirIdx  <= '0;
`ifdef ANT_SENSE_CENTER_EN
            centerPhase <= 1'b1;
`endif
            state   <= SCAN;
          end
        end
        SCAN: begin
          runMax  <= nextMax;
          runDir  <= nextDir;
          anyRead <= nextAny;
          if (stepDone) begin
            if (atCenter) begin
`ifdef ANT_SENSE_CENTER_EN
              centerPhase <= 1'b0;
              centerSig   <= rd_data;
`endif
            end else begin
              dirIdx <= dirIdx + 3'd1;
              if (dirIdx == 3'd7) begin
                best_dir    <= nextDir;
                best_signal <= nextMax;
                found       <= nextFound;
                state       <= DONE;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ant_signal_sensor.sv
// tb_ant_signal_sensor
//   Self-checking bench for ant_signal_sensor: a grid memory model answers
//   reads with a programmable wait, expected results and read addresses are
//   queued when a sense starts and compared when the DUT produces them.
module tb_ant_signal_sensor;
  localparam int SB = 16;
  localparam int GW = 64;
  localparam int GH = 64;
  localparam int XB = 6;
  localparam int YB = 6;

  logic          Clk = 1'b0;
  logic          Reset, start, rd_valid;
  logic [XB-1:0] ant_x, rd_x;
  logic [YB-1:0] ant_y, rd_y;
  logic [2:0]    cur_dir, best_dir;
  logic          rd_req, busy, done, found;
  logic [SB-1:0] rd_data, best_signal;

  always #5 Clk = ~Clk;

  ant_signal_sensor #(
    .SIGNAL_bits(SB), .GRID_W(GW), .GRID_H(GH),
    .X_bits(XB), .Y_bits(YB), .SENSE_THRESH(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .ant_x(ant_x), .ant_y(ant_y), .cur_dir(cur_dir),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done),
    .best_dir(best_dir), .best_signal(best_signal), .found(found)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          x, y, cdir;
    logic [15:0] fill, center;
    logic [15:0] nbr [8];
    int          waitCyc;
    bit          spurious, midStart;
    int          expDir, expSig;
    bit          expFound, expFoundCtr;
    int          expReads, expLat;
  } vec_t;

  typedef struct packed { logic [XB-1:0] x; logic [YB-1:0] y; } addr_t;
  typedef struct { int dir, sig, found, reads, lat; } result_t;

  localparam int NV = 8;
  vec_t        vecs [NV];
  logic [15:0] grid [GW][GH];
  addr_t       addrQ[$];
  result_t     resultQ[$];
  int dxT [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dyT [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  task automatic setVec(input int i, input int x, input int y, input int cdir,
                        input logic [15:0] fill, input logic [15:0] center,
                        input int waitCyc, input bit spurious, input bit midStart,
                        input int expDir, input int expSig, input bit expFound,
                        input bit expFoundCtr, input int expReads, input int expLat);
    vecs[i].x = x; vecs[i].y = y; vecs[i].cdir = cdir;
    vecs[i].fill = fill; vecs[i].center = center;
    vecs[i].waitCyc = waitCyc; vecs[i].spurious = spurious; vecs[i].midStart = midStart;
    vecs[i].expDir = expDir; vecs[i].expSig = expSig;
    vecs[i].expFound = expFound; vecs[i].expFoundCtr = expFoundCtr;
    vecs[i].expReads = expReads; vecs[i].expLat = expLat;
  endtask

  // Fill the grid for vector i and queue the on-grid addresses in read order.
  task automatic setupGrid(input int i);
    int nx, ny;
    for (int gx = 0; gx < GW; gx++)
      for (int gy = 0; gy < GH; gy++)
        grid[gx][gy] = vecs[i].fill;
    grid[vecs[i].x][vecs[i].y] = vecs[i].center;
`ifdef ANT_SENSE_CENTER_EN
    addrQ.push_back(addr_t'({XB'(vecs[i].x), YB'(vecs[i].y)}));
`endif
    for (int d = 0; d < 8; d++) begin
      nx = vecs[i].x + dxT[d];
      ny = vecs[i].y + dyT[d];
      if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
        grid[nx][ny] = vecs[i].nbr[d];
        addrQ.push_back(addr_t'({XB'(nx), YB'(ny)}));
      end
    end
  endtask

  task automatic runSense(input int i);
    result_t exp, got;
    int  cyc, waitCnt, reads;
    bit  gotDone, busyOk, stableOk;
    setupGrid(i);
    exp.dir = vecs[i].expDir;
    exp.sig = vecs[i].expSig;
`ifdef ANT_SENSE_CENTER_EN
    exp.found = vecs[i].expFoundCtr;
    exp.reads = vecs[i].expReads + 1;
    exp.lat   = vecs[i].expLat + 1 + vecs[i].waitCyc;
`else
    exp.found = vecs[i].expFound;
    exp.reads = vecs[i].expReads;
    exp.lat   = vecs[i].expLat;
`endif
    resultQ.push_back(exp);

    @(negedge Clk);
    start   = 1'b1;
    ant_x   = XB'(vecs[i].x);
    ant_y   = YB'(vecs[i].y);
    cur_dir = 3'(vecs[i].cdir);
    cyc = 0; waitCnt = 0; reads = 0;
    gotDone = 1'b0; busyOk = 1'b1; stableOk = 1'b1;
    while (!gotDone && cyc < 400) begin
      @(negedge Clk);
      cyc++;
      start    = vecs[i].midStart && (cyc == 10);
      rd_valid = 1'b0;
      rd_data  = '0;
      if (done) begin
        gotDone = 1'b1;
      end else begin
        if (!busy) busyOk = 1'b0;
        if (rd_req) begin
          if (addrQ.size() == 0 || addr_t'({rd_x, rd_y}) != addrQ[0]) stableOk = 1'b0;
          if (waitCnt == vecs[i].waitCyc) begin
            rd_valid = 1'b1;
            rd_data  = grid[rd_x][rd_y];
            reads++;
            if (addrQ.size() != 0) void'(addrQ.pop_front());
            waitCnt = 0;
          end else begin
            waitCnt++;
          end
        end else if (vecs[i].spurious) begin
          rd_valid = 1'b1;
          rd_data  = 16'hFFFF;
        end
      end
    end
    start    = 1'b0;
    rd_valid = 1'b0;
    if (!gotDone) check($sformatf("v%0d_timeout", i), 32'd0, 32'd1);
    got = resultQ.pop_front();
    check($sformatf("v%0d_best_dir", i), 32'(best_dir), 32'(got.dir));
    check($sformatf("v%0d_best_signal", i), 32'(best_signal), 32'(got.sig));
    check($sformatf("v%0d_found", i), 32'(found), 32'(got.found));
    check($sformatf("v%0d_latency", i), 32'(cyc), 32'(got.lat));
    check($sformatf("v%0d_reads", i), 32'(reads), 32'(got.reads));
    check($sformatf("v%0d_busy_during_scan", i), 32'(busyOk), 32'd1);
    check($sformatf("v%0d_addr_order_stable", i), 32'(stableOk), 32'd1);
    check($sformatf("v%0d_addr_left", i), 32'(addrQ.size()), 32'd0);
    addrQ.delete();
    @(negedge Clk);
    check($sformatf("v%0d_idle_after", i), 32'({busy, done, rd_req}), 32'd0);
    check($sformatf("v%0d_hold_signal", i), 32'(best_signal), 32'(got.sig));
  endtask

  initial begin
    int waitCnt, reads, cyc;
    Reset = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_data = '0;
    ant_x = '0; ant_y = '0; cur_dir = '0;

    //      i  x   y   cd fill ctr wait spur mid dir sig f  fc rds lat
    setVec(0, 10, 10, 0,  5,  5,  0,  0,  0,  2,  9, 1, 1,  8,  9);
    vecs[0].nbr = '{5, 5, 9, 5, 5, 5, 5, 5};
    setVec(1,  0,  0, 4,  0,  0,  0,  1,  0,  4,  7, 1, 1,  3,  9);
    vecs[1].nbr = '{0, 0, 3, 7, 7, 0, 0, 0};
    setVec(2, 20, 30, 6,  0,  0,  0,  0,  0,  6,  0, 0, 0,  8,  9);
    vecs[2].nbr = '{0, 0, 0, 0, 0, 0, 0, 0};
    setVec(3, 10, 10, 1,  0,  0,  3,  0,  1,  3,  6, 1, 1,  8, 33);
    vecs[3].nbr = '{4, 4, 2, 6, 6, 1, 0, 3};
    setVec(4, 63, 63, 0,  0,  0,  0,  0,  0,  7,  5, 1, 1,  3,  9);
    vecs[4].nbr = '{2, 0, 0, 0, 0, 0, 2, 5};
    setVec(5, 30,  5, 5,  3,  3,  0,  0,  0,  1,  7, 1, 1,  8,  9);
    vecs[5].nbr = '{0, 7, 7, 3, 3, 3, 3, 3};
    setVec(6, 10, 10, 0,  5,  9,  0,  0,  0,  2,  9, 1, 0,  8,  9);
    vecs[6].nbr = '{5, 5, 9, 5, 5, 5, 5, 5};
    setVec(7, 10, 10, 0,  5,  8,  0,  0,  0,  2,  9, 1, 1,  8,  9);
    vecs[7].nbr = '{5, 5, 9, 5, 5, 5, 5, 5};

    repeat (3) @(negedge Clk);
    check("reset_outputs", 32'({rd_req, busy, done, found}), 32'd0);
    check("reset_result", 32'({best_dir, best_signal}), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_no_start", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) runSense(i);

    // Abort during the 4th read: reset mid-wait, then a late rd_valid.
    setupGrid(3);
    addrQ.delete();
    @(negedge Clk);
    start = 1'b1; ant_x = 6'd10; ant_y = 6'd10; cur_dir = 3'd1;
    waitCnt = 0; reads = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge Clk);
      cyc++;
      start = 1'b0; rd_valid = 1'b0;
      if (rd_req) begin
        if (reads == 3 && waitCnt == 1) break;
        if (waitCnt == 3) begin
          rd_valid = 1'b1; rd_data = grid[rd_x][rd_y]; reads++; waitCnt = 0;
        end else waitCnt++;
      end
    end
    check("abort_reached_4th_read", 32'(cyc < 100), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_rd_req", 32'(rd_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outputs", 32'({done, found, best_dir, best_signal}), 32'd0);
    Reset = 1'b0;
    rd_valid = 1'b1; rd_data = 16'hFFFF;
    @(negedge Clk);
    rd_valid = 1'b0;
    @(negedge Clk);
    check("late_valid_ignored", 32'({busy, rd_req, best_signal}), 32'd0);

    runSense(0);
    runSense(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
